param_array_engine: RTL
=======================

Name: param_array_engine

Overview:
- Parametrised successor to the fixed four-entry test array FSM.
- A DEPTH x WIDTH register array that self-initialises after reset to the pattern 2*i+1.
- Once initialised, it serves single-index reads and writes, plus an auto-incrementing stream-read mode with optional wrap-around and out-of-range detection.
- Used as a storage and sequencing primitive by generated FSM designs and unit tests.

Parameters:
- WIDTH, 32: data width of each array entry.
- DEPTH, 4: number of entries; must be >= 2.
- IDX_W, 32: width of index and length inputs; full width is compared against DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_idx  in  IDX_W  write index.
- wr_data  in  WIDTH  write data.
- rd_req  in  1  single read request.
- rd_idx  in  IDX_W  read index; also the start index for a stream.
- stream_start  in  1  start a stream read.
- stream_len  in  IDX_W  number of entries to stream.
- wrap_en  in  1  stream wraps DEPTH-1 -> 0 instead of stopping.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  rd_data valid this cycle.
- rd_err  out  1  index out of range this cycle.
- wr_err  out  1  dropped out-of-range write.
- busy  out  1  high in INIT and STREAM.
- init_done  out  1  high once the initial fill has completed.

Behaviour:
- Reset:
  - One clock, reset is synchronous and active-high; port names are clk and reset.
  - On reset: rd_data=0, rd_valid=0, rd_err=0, wr_err=0, init_done=0, busy=1, state=INIT, fill pointer=0.
  - Array contents are not cleared directly; INIT overwrites every entry.
- State INIT:
  - Writes arr[p]=2*p+1, one entry per cycle, for p=0..DEPTH-1. Values are truncated to WIDTH.
  - After the write of p=DEPTH-1, the next cycle is IDLE with init_done=1 and busy=0. Total INIT length is DEPTH cycles.
  - All requests are ignored in INIT: no response, no error flags.
- State IDLE, single read:
  - rd_req samples rd_idx. One cycle later rd_valid=1 for exactly one cycle.
  - In range: rd_data=arr[rd_idx].
  - rd_idx>=DEPTH: rd_data=0 and rd_err=1.
- Writes (IDLE or STREAM):
  - wr_en with wr_idx<DEPTH writes at that edge.
  - wr_idx>=DEPTH: the write is dropped and wr_err pulses one cycle later.
- Read/write on the same index in the same cycle: the read returns the old value (read-before-write).
- Starting a stream (IDLE):
  - stream_start with stream_len>0 and rd_idx<DEPTH enters STREAM with cursor=rd_idx and remaining=stream_len.
  - stream_len==0: ignored, no response.
  - rd_idx>=DEPTH: one cycle of rd_valid=1, rd_err=1, rd_data=0, and the state stays IDLE.
  - stream_start and rd_req together: the stream wins.
- State STREAM:
  - Each cycle: rd_data<=arr[cursor], rd_valid=1, cursor++, remaining--. The first data appears one cycle after stream_start.
  - If cursor reaches DEPTH: wrap_en=1 sets cursor to 0; wrap_en=0 ends the stream after the DEPTH-1 element, even if remaining>0.
  - When remaining reaches 0, return to IDLE; rd_valid drops the following cycle.
  - rd_req and stream_start are ignored during STREAM.
  - A write landing on the element read in the same cycle returns the old value.
- Reset mid-operation: any state returns to INIT next cycle, with outputs as listed under Reset, and the fill restarts.
- rd_err and wr_err are never asserted in INIT.

Decomposition:
- Package param_array_pkg holds:
  - state enum {ST_INIT, ST_IDLE, ST_STREAM};
  - function init_value(i) returning 2*i+1;
  - localparam CNT_W=$clog2(DEPTH+1) helper.
- One sub-module, array_store: DEPTH x WIDTH storage with one write port and one synchronous read port, read-before-write.
- FSM, cursor and error logic live in param_array_engine.

Test Plan:
- Reset, then 4 idle cycles (DEPTH=4) -> init_done rises on cycle 5. Read idx 0..3 -> 1,3,5,7, each one cycle after rd_req.
- Stream start idx 1, len 3, wrap_en=0 -> rd_valid for 3 cycles with 3,5,7, then busy=0.
- Stream start idx 2, len 4, wrap_en=1 -> 5,7,1,3. Same with wrap_en=0 -> 5,7 and stop after 2 cycles.
- Read idx 4 -> rd_err=1, rd_data=0. Write idx 9 -> wr_err pulse, array unchanged. stream_start idx 5 -> single rd_err.
- Same-cycle wr idx 2 data 0xAA and rd idx 2 -> returns 5; next read idx 2 -> 0xAA.
- Assert reset during the second beat of a stream -> outputs 0 next cycle, INIT refill, read idx 2 after init -> 5.

Source files
------------

// File: rtl/param_array_pkg.sv
// Shared types and helpers for the parametrised array engine.
package param_array_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Fill pattern written during INIT; callers truncate to their data width.
    function automatic logic [63:0] init_value(input logic [31:0] i);
        return (64'(i) << 1) | 64'd1;
    endfunction

endpackage

// File: rtl/array_store.sv
// DEPTH x WIDTH register array: one write port, one registered read port.
module array_store #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a read of the address being written
    // in the same cycle returns the previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/param_array_engine.sv
// Self-initialising register array with single reads/writes and a streaming read mode.
module param_array_engine
    import param_array_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int IDX_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             stream_start,
    input  logic [IDX_W-1:0] stream_len,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err,
    output logic             wr_err,
    output logic             busy,
    output logic             init_done,
    output state_t           dbg_state
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    // Handshake: requests are single-cycle pulses sampled at the clock edge in IDLE;
    // the response (rd_valid with rd_data/rd_err, or wr_err) appears one cycle later
    // for exactly one cycle, except during a stream where rd_valid stays high per beat.

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [AW-1:0]    cursor_q, cursor_d;
    logic [IDX_W-1:0] remain_q, remain_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic             wr_err_q, wr_err_d;
    logic             data_ok_q, data_ok_d;
    logic             init_done_q, init_done_d;

    logic             mem_we, mem_re;
    logic [AW-1:0]    mem_waddr, mem_raddr;
    logic [WIDTH-1:0] mem_wdata, mem_rdata;

    logic             wr_ok, rd_ok;
    logic [AW-1:0]    step_idx, step_next;
    logic [IDX_W-1:0] step_rem, step_rem_next;
    logic             step_last, step_done;

    assign wr_ok = wr_idx < IDX_W'(DEPTH);
    assign rd_ok = rd_idx < IDX_W'(DEPTH);

    // One stream beat: the start cycle reads rd_idx, later beats read the cursor.
    assign step_idx      = (state_q == ST_STREAM) ? cursor_q : rd_idx[AW-1:0];
    assign step_rem      = (state_q == ST_STREAM) ? remain_q : stream_len;
    assign step_last     = step_idx == AW'(DEPTH - 1);
    assign step_next     = step_last ? '0 : step_idx + AW'(1);
    assign step_rem_next = step_rem - IDX_W'(1);
    assign step_done     = (step_rem_next == '0) || (step_last && !wrap_en);

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        cursor_d    = cursor_q;
        remain_d    = remain_q;
        rd_valid_d  = 1'b0;
        rd_err_d    = 1'b0;
        wr_err_d    = 1'b0;
        data_ok_d   = data_ok_q;
        init_done_d = init_done_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_idx[AW-1:0];
        mem_wdata   = wr_data;
        mem_re      = 1'b0;
        mem_raddr   = step_idx;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = fill_q[AW-1:0];
                mem_wdata = WIDTH'(init_value(32'(fill_q)));
                if (fill_q == CNT_W'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    fill_d = fill_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                mem_we   = wr_en && wr_ok;
                wr_err_d = wr_en && !wr_ok;
                if (stream_start) begin
                    if (stream_len != '0) begin
                        rd_valid_d = 1'b1;
                        if (rd_ok) begin
                            mem_re    = 1'b1;
                            data_ok_d = 1'b1;
                            cursor_d  = step_next;
                            remain_d  = step_rem_next;
                            state_d   = step_done ? ST_IDLE : ST_STREAM;
                        end else begin
                            rd_err_d  = 1'b1;
                            data_ok_d = 1'b0;
                        end
                    end
                end else if (rd_req) begin
                    rd_valid_d = 1'b1;
                    if (rd_ok) begin
                        mem_re    = 1'b1;
                        data_ok_d = 1'b1;
                    end else begin
                        rd_err_d  = 1'b1;
                        data_ok_d = 1'b0;
                    end
                end
            end

            ST_STREAM: begin
                mem_we     = wr_en && wr_ok;
                wr_err_d   = wr_en && !wr_ok;
                mem_re     = 1'b1;
                rd_valid_d = 1'b1;
                data_ok_d  = 1'b1;
                cursor_d   = step_next;
                remain_d   = step_rem_next;
                state_d    = step_done ? ST_IDLE : ST_STREAM;
            end

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            fill_q      <= '0;
            cursor_q    <= '0;
            remain_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            data_ok_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            cursor_q    <= cursor_d;
            remain_q    <= remain_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
            wr_err_q    <= wr_err_d;
            data_ok_q   <= data_ok_d;
            init_done_q <= init_done_d;
        end
    end

    array_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk   (clk),
        .we    (mem_we && !reset),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // The store's read register is not reset; data_ok_q masks it to zero
    // after reset and after an out-of-range read.
    assign rd_data   = data_ok_q ? mem_rdata : '0;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign wr_err    = wr_err_q;
    assign busy      = state_q != ST_IDLE;
    assign init_done = init_done_q;
    assign dbg_state = state_q;

endmodule
